io_pad_arbiter: RTL and testbench
=================================

// Module: io_pad_arbiter
// PURPOSE
// - Shares one bank of user GPIO pads (io_out/io_oeb) among N_REQ internal requesters.
// - Sits inside user_project_wrapper between the user macros and the io_out/io_oeb pins.
// - Round-robin arbitration with a hold timeout and a tristated turnaround cycle.
// - Configured and observed through a Wishbone slave; optional owner-change interrupt.
// PARAMETERS
// - N_REQ     4            number of requesters (2..8)
// - PADS      38           pads in the shared bank
// - BASE_ADDR 32'h3000_0000 Wishbone base; decode on wbs_adr_i[31:4]
// - TO_W      16           width of the hold-timeout counter
// PORTS
// - wb_clk_i    in   1          clock
// - wb_rst_i    in   1          reset, asynchronous, active-high
// - wbs_stb_i   in   1          WB strobe
// - wbs_cyc_i   in   1          WB cycle
// - wbs_we_i    in   1          WB write enable
// - wbs_sel_i   in   4          WB byte selects
// - wbs_adr_i   in   32         WB address
// - wbs_dat_i   in   32         WB write data
// - wbs_ack_o   out  1          WB acknowledge
// - wbs_dat_o   out  32         WB read data
// - req_i       in   N_REQ      per-requester pad-bank request, level
// - req_out_i   in   N_REQ*PADS requester k drives bits [k*PADS +: PADS]
// - req_oeb_i   in   N_REQ*PADS requester k output-enable-bar, same packing
// - gnt_o       out  N_REQ      one-hot grant, at most one bit set
// - io_out      out  PADS       to pads
// - io_oeb      out  PADS       to pads, 1 = input/tristate
// - irq_o       out  1          owner-change interrupt (see CONFIGURATION)
// BEHAVIOUR
// - Reset: gnt_o=0, io_out=0, io_oeb=all 1, wbs_ack_o=0, wbs_dat_o=0, irq_o=0, regs=0, state IDLE, rr pointer=0.
// - Registers (word offset): 0x0 CTRL[0]=EN; 0x4 TIMEOUT[TO_W-1:0] (0=no timeout);
//   0x8 STATUS RO {busy[8], owner[2:0]}; 0xC IRQ RO/W1C [0]=owner-change pending. Other offsets read 0, writes ignored.
// - WB: ack one cycle after stb&cyc&addr-hit, one-cycle pulse; ack low the cycle after; writes honour wbs_sel_i per byte.
// - FSM IDLE: EN=1 and any req_i -> GRANT to first requester at/after rr pointer (wrapping); gnt_o set next cycle.
// - FSM GRANT: io_out/io_oeb = owner's slice, combinational from req_out_i/req_oeb_i; hold counter increments per cycle.
//   Exit to TURN when owner drops req_i, EN cleared, or (TIMEOUT!=0, counter==TIMEOUT, another req_i high).
//   Counter saturates at TIMEOUT when no one else waits; owner keeps bank.
// - FSM TURN: exactly one cycle; gnt_o=0, io_out=0, io_oeb=all 1; rr pointer = owner+1 mod N_REQ; -> IDLE.
// - Grant latency: request to gnt_o = 1 cycle from IDLE; worst case after release = 2 cycles (TURN + IDLE).
// - Outside GRANT, pads are always tristated (io_oeb=1, io_out=0).
// - Simultaneous CTRL write EN=0 and grant decision: EN=0 wins, no grant issued.
// - Timeout expiry same cycle owner drops req_i: single TURN, no double count.
// - Reset mid-grant: pads tristate immediately (async), grant dropped.
// - STATUS.owner valid only while busy=1; reads 0 otherwise.
// CONFIGURATION
// - IO_PAD_ARB_IRQ_EN defined: IRQ[0] set on every GRANT entry; irq_o=IRQ[0]; W1C clears;
//   set and clear same cycle -> set wins.
// - Not defined: irq_o tied 0, IRQ reads 0, writes ignored; no flop inferred.
// TESTING
// - Reset, no EN, req_i=4'b0001 -> gnt_o stays 0, io_oeb=all 1 for 20 cycles.
// - EN=1, req_i=4'b0101 -> gnt_o=0001 next cycle; release -> 1 TURN cycle tristate, then gnt_o=0100.
// - TIMEOUT=8, req0 held, req2 waiting -> req0 owns exactly 8 cycles, TURN, gnt_o=0100; alone req0 holds indefinitely.
// - Owner req1 drives req_out slice=38'h15 oeb=0 -> io_out=38'h15, io_oeb=0; STATUS reads 0x101.
// - Assert wb_rst_i mid-GRANT -> gnt_o=0, io_oeb=all 1 same cycle without clock edge.
// - IO_PAD_ARB_IRQ_EN: grant -> irq_o=1; write IRQ=1 -> irq_o=0 next cycle; without macro irq_o always 0.

Source files
------------

// File: rtl/io_pad_arbiter.sv
// io_pad_arbiter: round-robin owner of a shared GPIO pad bank (req_i/req_out_i/req_oeb_i -> gnt_o/io_out/io_oeb, one tristated turnaround cycle between owners) configured through Wishbone registers CTRL/TIMEOUT/STATUS/IRQ; define IO_PAD_ARB_IRQ_EN to enable the owner-change interrupt irq_o
module io_pad_arbiter #(
  parameter int N_REQ = 4,
  parameter int PADS = 38,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int TO_W = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ*PADS-1:0] req_out_i,
  input  logic [N_REQ*PADS-1:0] req_oeb_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic [PADS-1:0]       io_out,
  output logic [PADS-1:0]       io_oeb,
  output logic                  irq_o
);
  localparam int OW = $clog2(N_REQ);
  localparam logic [OW:0] NR = (OW+1)'(N_REQ);
  localparam logic [OW-1:0] LAST = OW'(N_REQ-1);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  state_t state, state_nxt;
  logic [OW-1:0] owner, owner_nxt, rr, rr_nxt, off_pick, pick;
  logic [OW:0] s;
  logic [N_REQ-1:0] rot, own_oh;
  logic [TO_W-1:0] cnt, cnt_nxt, tmo;
  logic [31:0] wmask, tmo_w, rdata, irq_rd;
  logic [1:0] off;
  logic en, en_eff, wb_req, wb_wr, busy, expire, unused;
  assign unused = ^wbs_adr_i[1:0];
  assign wb_req = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
  assign wb_wr = wb_req & wbs_we_i;
  assign off = wbs_adr_i[3:2];
  assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign tmo_w = (32'(tmo) & ~wmask) | (wbs_dat_i & wmask);
  // A CTRL write lands on the same edge as the arbitration decision, so the decision sees the written EN.
  assign en_eff = (wb_wr && off == 2'd0 && wbs_sel_i[0]) ? wbs_dat_i[0] : en;
  assign busy = state == GRANT;
  assign own_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
  assign gnt_o = busy ? own_oh : '0;
  assign io_out = busy ? req_out_i[owner*PADS +: PADS] : '0;
  assign io_oeb = busy ? req_oeb_i[owner*PADS +: PADS] : '1;
  assign expire = tmo != '0 && cnt >= tmo && |(req_i & ~own_oh);
  // Rotate requests so bit 0 is the rr pointer; the lowest set bit is the next owner's distance from it.
  assign rot = (req_i >> rr) | (req_i << (NR - {1'b0, rr}));
  always_comb begin
    off_pick = '0;
    for (int i = N_REQ-1; i >= 0; i--) if (rot[i]) off_pick = OW'(i);
  end
  assign s = {1'b0, rr} + {1'b0, off_pick};
  assign pick = s >= NR ? OW'(s - NR) : OW'(s);
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt = rr;
    cnt_nxt = cnt;
    if (state == IDLE) begin
      if (en_eff && |req_i) begin
        state_nxt = GRANT;
        owner_nxt = pick;
        cnt_nxt = TO_W'(1);
      end
    end else if (state == GRANT) begin
      if (!(|(req_i & own_oh)) || !en_eff || expire) state_nxt = TURN;
      else if ((tmo == '0 || cnt < tmo) && cnt != '1) cnt_nxt = cnt + 1'b1;
    end else begin
      state_nxt = IDLE;
      rr_nxt = owner == LAST ? '0 : owner + 1'b1;
    end
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      owner <= '0;
      rr <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      rr <= rr_nxt;
      cnt <= cnt_nxt;
    end
  end
  assign rdata = off == 2'd0 ? {31'b0, en} :
                 off == 2'd1 ? 32'(tmo) :
                 off == 2'd2 ? (busy ? 32'h100 | 32'(owner) : '0) : irq_rd;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      en <= 1'b0;
      tmo <= '0;
    end else begin
      wbs_ack_o <= wb_req;
      wbs_dat_o <= (wb_req && !wbs_we_i) ? rdata : '0;
      en <= en_eff;
      if (wb_wr && off == 2'd1) tmo <= tmo_w[TO_W-1:0];
    end
  end
`ifdef IO_PAD_ARB_IRQ_EN
  logic irq_pend;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) irq_pend <= 1'b0;
    else irq_pend <= (state == IDLE && state_nxt == GRANT) | (irq_pend & ~(wb_wr && off == 2'd3 && wbs_sel_i[0] && wbs_dat_i[0]));
  end
  assign irq_o = irq_pend;
  assign irq_rd = {31'b0, irq_pend};
`else
  assign irq_o = 1'b0;
  assign irq_rd = '0;
`endif
endmodule

// File: tb/tb_io_pad_arbiter.sv
// tb_io_pad_arbiter: directed and random checks of io_pad_arbiter against a cycle-level reference model
module tb_io_pad_arbiter;
  localparam int N = 4;
  localparam int P = 38;
  localparam int W = N*P;
`ifdef IO_PAD_ARB_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic clk = 0, rst = 1, stb = 0, cyc = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, wdat = 0;
  logic ack, irq;
  logic [31:0] rdat;
  logic [N-1:0] req = 0, gnt;
  logic [W-1:0] rout = 0, roeb = '1;
  logic [P-1:0] io_out, io_oeb;
  int checks = 0, errors = 0;
  int m_own, m_rr, m_held;
  bit m_turn, m_en, m_irq, m_ack;
  logic [15:0] m_to;
  logic [31:0] m_dat;
  always #5 clk = ~clk;
  io_pad_arbiter dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .req_i(req), .req_out_i(rout), .req_oeb_i(roeb), .gnt_o(gnt), .io_out(io_out),
    .io_oeb(io_oeb), .irq_o(irq)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_own = -1; m_rr = 0; m_held = 0; m_turn = 0; m_en = 0; m_irq = 0; m_ack = 0;
    m_to = 0; m_dat = 0;
  endtask
  function automatic logic [W-1:0] rnd();
    logic [159:0] t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction
  task automatic model_step();
    bit hit, rq, en_n, clr, set, oth;
    logic [1:0] o;
    logic [31:0] rd;
    logic [15:0] to_old;
    hit = stb && cyc && adr[31:4] == 28'h300_0000;
    rq = hit && !m_ack;
    o = adr[3:2];
    to_old = m_to;
    rd = o == 0 ? {31'b0, m_en} : o == 1 ? {16'b0, m_to} :
         o == 2 ? ((m_own >= 0 && !m_turn) ? 32'h100 + 32'(m_own) : 32'h0) : {31'b0, IRQ & m_irq};
    m_ack = rq;
    m_dat = (rq && !we) ? rd : 32'h0;
    en_n = m_en; clr = 0; set = 0;
    if (rq && we) begin
      if (o == 0 && sel[0]) en_n = wdat[0];
      if (o == 1 && sel[0]) m_to[7:0] = wdat[7:0];
      if (o == 1 && sel[1]) m_to[15:8] = wdat[15:8];
      if (o == 3 && sel[0] && wdat[0]) clr = 1;
    end
    if (m_turn) begin
      m_rr = (m_own + 1) % N; m_own = -1; m_turn = 0;
    end else if (m_own < 0) begin
      if (en_n && req != 0) begin
        for (int k = 0; k < N; k++) if (m_own < 0 && req[(m_rr + k) % N]) m_own = (m_rr + k) % N;
        m_held = 1; set = 1;
      end
    end else begin
      oth = (req & ~(4'b1 << m_own)) != 0;
      if (!req[m_own] || !en_n || (to_old != 0 && m_held >= to_old && oth)) m_turn = 1;
      else if (to_old == 0 || m_held < to_old) m_held++;
    end
    m_en = en_n;
    m_irq = IRQ && (set || (m_irq && !clr));
  endtask
  task automatic tick();
    bit own;
    logic [N-1:0] eg;
    logic [P-1:0] eo, ee;
    model_step();
    @(posedge clk); #1;
    own = m_own >= 0 && !m_turn;
    eg = own ? 4'b1 << m_own : 4'b0;
    eo = own ? rout[m_own*P +: P] : '0;
    ee = own ? roeb[m_own*P +: P] : '1;
    chk("gnt", gnt, eg); chk("io_out", io_out, eo); chk("io_oeb", io_oeb, ee);
    chk("ack", ack, m_ack); chk("dat", rdat, m_dat); chk("irq", irq, m_irq);
  endtask
  task automatic wb(input bit w, input logic [3:0] off, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    stb = 1; cyc = 1; we = w; adr = 32'h3000_0000 | {28'b0, off}; wdat = d; sel = s;
    tick(); r = rdat;
    stb = 0; cyc = 0; we = 0;
    tick();
  endtask
  task automatic wait_gnt(input logic [N-1:0] g, input string tag);
    int n = 0;
    while (gnt !== g && n < 10) begin tick(); n++; end
    chk(tag, gnt, g);
  endtask
  initial begin
    logic [31:0] r;
    int cnt;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0); chk("rst_oeb", io_oeb, {P{1'b1}}); chk("rst_out", io_out, 0);
    chk("rst_ack", ack, 0); chk("rst_dat", rdat, 0); chk("rst_irq", irq, 0);
    @(negedge clk) rst = 0;
    req = 4'b0001;
    repeat (20) tick();
    chk("noen_gnt", gnt, 0); chk("noen_oeb", io_oeb, {P{1'b1}});
    req = 0;
    wb(1, 4'h0, 32'h1, 4'hf, r);
    req = 4'b0101; tick(); chk("g0", gnt, 4'b0001);
    req = 4'b0100; tick(); chk("turn_gnt", gnt, 0); chk("turn_oeb", io_oeb, {P{1'b1}});
    tick(); chk("idle_gnt", gnt, 0);
    tick(); chk("g2", gnt, 4'b0100);
    wb(1, 4'h4, 32'd8, 4'hf, r);
    req = 0; tick(); tick();
    req = 4'b0101; tick(); chk("to_g0", gnt, 4'b0001);
    cnt = 0;
    while (gnt === 4'b0001 && cnt < 50) begin cnt++; tick(); end
    chk("to_len", cnt, 8); chk("to_turn", gnt, 0);
    tick(); chk("to_idle", gnt, 0);
    tick(); chk("to_g2", gnt, 4'b0100);
    req = 4'b0001;
    repeat (40) tick();
    chk("hold", gnt, 4'b0001);
    rout = rnd(); roeb = rnd();
    rout[P +: P] = 38'h15; roeb[P +: P] = '0;
    req = 4'b0010;
    wait_gnt(4'b0010, "g1");
    chk("g1_out", io_out, 38'h15); chk("g1_oeb", io_oeb, 0);
    wb(0, 4'h8, 32'h0, 4'hf, r);
    chk("status", r, 32'h101);
    chk("irq_set", irq, IRQ);
    wb(1, 4'hc, 32'h1, 4'h1, r);
    chk("irq_clr", irq, 0);
    req = 0; tick(); tick();
    req = 4'b0001;
    wb(1, 4'h0, 32'h0, 4'h1, r);
    chk("en0_wins", gnt, 0);
    repeat (3) tick();
    chk("en0_stay", gnt, 0);
    wb(1, 4'h0, 32'h1, 4'h1, r);
    wb(1, 4'h4, 32'd3, 4'h3, r);
    for (int it = 0; it < 400; it++) begin
      req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin rout = rnd(); roeb = rnd(); end
      if (!stb && $urandom_range(0, 5) == 0) begin
        stb = 1; cyc = 1; we = 1'($urandom); sel = 4'($urandom); wdat = $urandom;
        adr = 32'h3000_0000 | {28'b0, 2'($urandom), 2'b0};
        if ($urandom_range(0, 7) == 0) adr = 32'h3000_0010;
        if (adr[3:2] == 0) wdat[0] = $urandom_range(0, 7) != 0;
        if (adr[3:2] == 1) wdat = $urandom_range(0, 6);
      end else if (stb && $urandom_range(0, 1) == 0) begin
        stb = 0; cyc = 0; we = 0;
      end
      tick();
    end
    stb = 0; cyc = 0; we = 0;
    tick();
    wb(1, 4'h0, 32'h1, 4'hf, r);
    req = 4'b1000;
    wait_gnt(4'b1000, "g3");
    #2 rst = 1;
    #1;
    chk("arst_gnt", gnt, 0); chk("arst_oeb", io_oeb, {P{1'b1}}); chk("arst_out", io_out, 0);
    m_reset();
    @(negedge clk) rst = 0;
    tick();
    chk("post_rst_gnt", gnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
